// File: rtl/fsm_run_length_encoder.sv
// Run-length encoder for the single-bit FSM output stream.
// Tracks how many enabled samples the level holds and pushes {level, length}
// tokens into a small show-ahead FIFO drained by a valid/ready handshake.
module fsm_run_length_encoder #(
  parameter int CNT_W   = 8,
  parameter int FIFO_AW = 2
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               en,
  input  logic               level_in,
  input  logic               flush,
  output logic               tok_valid,
  input  logic               tok_ready,
  output logic               tok_level,
  output logic [CNT_W-1:0]   tok_len,
  output logic [FIFO_AW:0]   fifo_level,
  output logic               overflow,
  input  logic               clr_ovf
);

  localparam int                DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]  FULL_CNT = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]  CNT_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [CNT_W-1:0]  MAX_LEN  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  LEN_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LEN_ZERO = CNT_W'(0);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Tracker state
  state_t            state_r;
  logic              cur_level_r;
  logic [CNT_W-1:0]  run_len_r;

  // FIFO state; each entry is {level, length}
  logic [CNT_W:0]    mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r;
  logic [FIFO_AW-1:0] rd_ptr_r;
  logic [FIFO_AW:0]  count_r;
  logic              valid_r;
  logic              head_level_r;
  logic [CNT_W-1:0]  head_len_r;
  logic              overflow_r;

  // Combinational decisions
  logic              emit_s;
  logic              emit_level_s;
  logic [CNT_W-1:0]  emit_len_s;
  logic              pop_s;
  logic              full_s;
  logic              push_s;
  logic              drop_s;
  logic [FIFO_AW:0]  count_next_s;
  logic [FIFO_AW-1:0] rd_next_s;
  logic [CNT_W:0]    head_next_s;

  assign tok_valid  = valid_r;
  assign tok_level  = head_level_r;
  assign tok_len    = head_len_r;
  assign fifo_level = count_r;
  assign overflow   = overflow_r;

  // Decide whether this edge terminates a run and what token it carries
  always_comb begin
    emit_s       = 1'b0;
    emit_level_s = cur_level_r;
    emit_len_s   = run_len_r;
    case (state_r)
      RUN: begin
        if (flush) begin
          emit_s = 1'b1;
        end else if (en && (level_in != cur_level_r)) begin
          emit_s = 1'b1;
        end else if (en && (run_len_r == MAX_LEN)) begin
          emit_s = 1'b1;
        end else begin
          emit_s = 1'b0;
        end
      end
      default: begin
        emit_s = 1'b0;
      end
    endcase
  end

  // Run tracker FSM: flush beats en, a saturated run is split instead of wrapping
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r     <= IDLE;
      cur_level_r <= 1'b0;
      run_len_r   <= LEN_ZERO;
    end else begin
      case (state_r)
        IDLE: begin
          if (flush) begin
            state_r <= IDLE;
          end else if (en) begin
            state_r     <= RUN;
            cur_level_r <= level_in;
            run_len_r   <= LEN_ONE;
          end
        end
        RUN: begin
          if (flush) begin
            state_r   <= IDLE;
            run_len_r <= LEN_ZERO;
          end else if (en) begin
            if (level_in != cur_level_r) begin
              cur_level_r <= level_in;
              run_len_r   <= LEN_ONE;
            end else if (run_len_r == MAX_LEN) begin
              run_len_r <= LEN_ONE;
            end else begin
              run_len_r <= run_len_r + LEN_ONE;
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          run_len_r <= LEN_ZERO;
        end
      endcase
    end
  end

  // FIFO next-state: a pop frees the slot so a push into a full FIFO is still accepted
  always_comb begin
    pop_s  = valid_r & tok_ready;
    full_s = (count_r == FULL_CNT);
    push_s = emit_s & (~full_s | pop_s);
    drop_s = emit_s & full_s & ~pop_s;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + CNT_ONE;
      2'b01:   count_next_s = count_r - CNT_ONE;
      default: count_next_s = count_r;
    endcase
    if (pop_s) begin
      rd_next_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_next_s = rd_ptr_r;
    end
    // The new head is the token being written when it lands in the head slot
    if (push_s && (wr_ptr_r == rd_next_s)) begin
      head_next_s = {emit_level_s, emit_len_s};
    end else begin
      head_next_s = mem_r[rd_next_s];
    end
  end

  // FIFO storage write; contents are only read once written, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {emit_level_s, emit_len_s};
    end
  end

  // FIFO pointers, registered head outputs and sticky overflow (set beats clear)
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      count_r      <= '0;
      valid_r      <= 1'b0;
      head_level_r <= 1'b0;
      head_len_r   <= LEN_ZERO;
      overflow_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r     <= rd_next_s;
      count_r      <= count_next_s;
      valid_r      <= (count_next_s != '0);
      head_level_r <= head_next_s[CNT_W];
      head_len_r   <= head_next_s[CNT_W-1:0];
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fsm_run_length_encoder.sv
// Self-checking bench for fsm_run_length_encoder: vector table, directed
// corner sequences and randomized traffic against a token-queue reference.
module tb_fsm_run_length_encoder;

  localparam int CNT_W   = 8;
  localparam int FIFO_AW = 2;
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int MAXLEN  = (1 << CNT_W) - 1;

  logic               clk;
  logic               areset;
  logic               en;
  logic               level_in;
  logic               flush;
  logic               tok_valid;
  logic               tok_ready;
  logic               tok_level;
  logic [CNT_W-1:0]   tok_len;
  logic [FIFO_AW:0]   fifo_level;
  logic               overflow;
  logic               clr_ovf;

  fsm_run_length_encoder #(.CNT_W(CNT_W), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .areset(areset), .en(en), .level_in(level_in), .flush(flush),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_level(tok_level),
    .tok_len(tok_len), .fifo_level(fifo_level), .overflow(overflow),
    .clr_ovf(clr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the current run as (level, sample count) and the FIFO as a token queue
  typedef struct { int lvl; int len; } tok_t;
  tok_t m_q[$];
  bit   m_in_run;
  int   m_level;
  int   m_len;
  bit   m_ovf;

  typedef struct {
    logic en, lvl, flush, rdy, clr;
    logic ev;
    int   el, elen, efl;
    logic eovf;
  } vec_t;
  vec_t vt[19];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_in_run = 1'b0;
    m_level  = 0;
    m_len    = 0;
    m_ovf    = 1'b0;
  endtask

  task automatic model_step(input bit e, input bit l, input bit f, input bit r, input bit c);
    bit   emit;
    bit   drop;
    tok_t t;
    emit = 1'b0;
    drop = 1'b0;
    t = '{0, 0};
    if (f) begin
      if (m_in_run) begin
        emit = 1'b1; t = '{m_level, m_len};
        m_in_run = 1'b0; m_len = 0;
      end
    end else if (e) begin
      if (!m_in_run) begin
        m_in_run = 1'b1; m_level = int'(l); m_len = 1;
      end else if (int'(l) != m_level) begin
        emit = 1'b1; t = '{m_level, m_len};
        m_level = int'(l); m_len = 1;
      end else if (m_len == MAXLEN) begin
        emit = 1'b1; t = '{m_level, MAXLEN};
        m_len = 1;
      end else begin
        m_len++;
      end
    end
    if (r && m_q.size() > 0) void'(m_q.pop_front());
    if (emit) begin
      if (m_q.size() < DEPTH) m_q.push_back(t);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (c) m_ovf = 1'b0;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, "_valid"}, int'(tok_valid), int'(m_q.size() > 0));
    chk({tag, "_fifo_level"}, int'(fifo_level), m_q.size());
    chk({tag, "_overflow"}, int'(overflow), int'(m_ovf));
    if (m_q.size() > 0) begin
      chk({tag, "_tok_level"}, int'(tok_level), m_q[0].lvl);
      chk({tag, "_tok_len"}, int'(tok_len), m_q[0].len);
    end
  endtask

  task automatic step(input bit e, input bit l, input bit f, input bit r, input bit c, input string tag);
    en = e; level_in = l; flush = f; tok_ready = r; clr_ovf = c;
    @(posedge clk);
    model_step(e, l, f, r, c);
    #1;
    cmp_model(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; level_in = 1'b0; flush = 1'b0; tok_ready = 1'b0; clr_ovf = 1'b0;
    areset = 1'b1;
    #1;
    model_reset();
    cmp_model("reset");
    chk("reset_tok_len_zero", int'(tok_len), 0);
    @(negedge clk);
    areset = 1'b0;
  endtask

  initial begin
    bit rl;
    areset = 1'b1;
    en = 1'b0; level_in = 1'b0; flush = 1'b0; tok_ready = 1'b0; clr_ovf = 1'b0;
    model_reset();

    // {en, lvl, flush, rdy, clr, exp_valid, exp_level, exp_len, exp_fifo_level, exp_ovf}
    vt[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0};
    vt[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0};
    vt[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 1, 1'b0};
    vt[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 1, 1'b0};
    vt[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 1, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 1, 1'b0};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 1, 1'b0};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 1, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 1, 1'b0};
    vt[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1, 3, 2, 1'b0};
    vt[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, 3, 2, 1'b0};
    vt[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 2, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 3, 3, 1'b0};
    vt[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0, 7, 2, 1'b0};
    vt[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1, 1, 1'b0};
    vt[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0};
    vt[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1, 1, 1'b0};
    vt[18] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 0, 1'b0};

    do_reset();

    // Basic encoding, flush with priority over en, flush in IDLE, drain order
    for (int i = 0; i < 19; i++) begin
      step(vt[i].en, vt[i].lvl, vt[i].flush, vt[i].rdy, vt[i].clr, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_valid_tbl", i), int'(tok_valid), int'(vt[i].ev));
      chk($sformatf("vec%0d_fifo_tbl", i), int'(fifo_level), vt[i].efl);
      chk($sformatf("vec%0d_ovf_tbl", i), int'(overflow), int'(vt[i].eovf));
      if (vt[i].ev) begin
        chk($sformatf("vec%0d_level_tbl", i), int'(tok_level), vt[i].el);
        chk($sformatf("vec%0d_len_tbl", i), int'(tok_len), vt[i].elen);
      end
    end

    // Long run is split at the maximum length
    do_reset();
    for (int i = 0; i < 257; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "long");
    chk("long_one_token", int'(fifo_level), 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "long_end");
    chk("long_two_tokens", int'(fifo_level), 2);
    chk("long_first_len", int'(tok_len), 255);
    chk("long_first_level", int'(tok_level), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "long_pop");
    chk("long_second_len", int'(tok_len), 2);
    chk("long_second_level", int'(tok_level), 1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "long_pop2");

    // Overflow with a stalled consumer, drain order, clear
    do_reset();
    for (int i = 0; i < 13; i++) step(1'b1, 1'((i / 2) % 2), 1'b0, 1'b0, 1'b0, "ovf_fill");
    chk("ovf_fifo_full", int'(fifo_level), 4);
    chk("ovf_sticky", int'(overflow), 1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf_drain%0d_level", k), int'(tok_level), k % 2);
      chk($sformatf("ovf_drain%0d_len", k), int'(tok_len), 2);
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ovf_drain");
    end
    chk("ovf_after_drain", int'(overflow), 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ovf_clr");
    chk("ovf_cleared", int'(overflow), 0);

    // Full FIFO, push and pop on the same edge
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "full_pp");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "full_pp");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "full_pp");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "full_pp");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "full_pp");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "full_pp");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "full_pp");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "full_pp");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "full_pp");
    chk("pp_full_before", int'(fifo_level), 4);
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "full_pp_edge");
    chk("pp_level_stays", int'(fifo_level), 4);
    chk("pp_no_overflow", int'(overflow), 0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "pp_drain");
    chk("pp_tail_level", int'(tok_level), 0);
    chk("pp_tail_len", int'(tok_len), 2);
    chk("pp_tail_count", int'(fifo_level), 1);

    // Asynchronous reset between edges mid-run with stored tokens
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ar_fill");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ar_fill");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ar_fill");
    chk("ar_two_tokens", int'(fifo_level), 2);
    #3;
    areset = 1'b1;
    #1;
    model_reset();
    chk("ar_valid_now", int'(tok_valid), 0);
    chk("ar_fifo_now", int'(fifo_level), 0);
    chk("ar_ovf_now", int'(overflow), 0);
    #2;
    areset = 1'b0;
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ar_after");
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "ar_after");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "ar_after");
    chk("ar_new_run_len", int'(tok_len), 2);
    chk("ar_new_run_level", int'(tok_level), 1);

    // Randomized traffic, short runs and a slow consumer
    rl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rl = ~rl;
      step($urandom_range(0, 3) != 0, rl, $urandom_range(0, 31) == 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0, "rand");
    end
    // Randomized traffic, long runs crossing the split length
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) rl = ~rl;
      step($urandom_range(0, 7) != 0, rl, $urandom_range(0, 999) == 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, "rand_long");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
